// File: rtl/sub32_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sub32_seq_if
// Brief    : Operand/result handshake bundle for the sequential subtractor.
// Revision : 1.0
// ============================================================================
interface sub32_seq_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         i_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_in;
    logic         o_valid;
    logic         o_ready;
    logic [N-1:0] diff;
    logic         b_out;
    logic         zero;
    logic         neg;
    logic         ovf;

    modport master (
        output i_valid, a, b, b_in, o_ready,
        input  i_ready, o_valid, diff, b_out, zero, neg, ovf
    );

    modport slave (
        input  i_valid, a, b, b_in, o_ready,
        output i_ready, o_valid, diff, b_out, zero, neg, ovf
    );
endinterface
`default_nettype wire

// File: rtl/sub32_seq.sv
`default_nettype none
// ============================================================================
// Module   : sub32_seq
// Brief    : Multi-cycle N-bit subtractor, W bits per cycle, with ALU flags.
// Revision : 1.0
// ============================================================================
module sub32_seq #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  wire logic     clk,
    input  wire logic     rst,
    sub32_seq_if.slave    bus
);
    localparam int        c_NCH   = N / W;
    localparam int        c_KW    = (c_NCH > 1) ? $clog2(c_NCH) : 1;
    localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_NCH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [c_KW-1:0]   r_k;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_b;
    logic              r_borrow;
    logic [N-1:0]      r_diff;
    logic              r_b_out;
    logic              r_zero;
    logic              r_neg;
    logic              r_ovf;
    logic              r_o_valid;
    logic              r_i_ready;

    logic [W-1:0]      w_a_sl;
    logic [W-1:0]      w_b_sl;
    logic [W:0]        w_sub;
    logic [N-1:0]      w_diff_next;

    // One W-bit borrow-chained slice; the top bit of w_sub is the slice borrow.
    always_comb begin
        w_a_sl      = r_a[r_k*W +: W];
        w_b_sl      = r_b[r_k*W +: W];
        w_sub       = {1'b0, w_a_sl} - {1'b0, w_b_sl} - {{W{1'b0}}, r_borrow};
        w_diff_next = r_diff;
        w_diff_next[r_k*W +: W] = w_sub[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_k       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_borrow  <= 1'b0;
            r_diff    <= '0;
            r_b_out   <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_o_valid <= 1'b0;
            r_i_ready <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.i_valid) begin
                        r_a       <= bus.a;
                        r_b       <= bus.b;
                        r_borrow  <= bus.b_in;
                        r_k       <= '0;
                        r_i_ready <= 1'b0;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_sub[W];
                    if (r_k == c_K_LAST) begin
                        // Flags come from the completed word and the final borrow.
                        r_k       <= '0;
                        r_b_out   <= w_sub[W];
                        r_zero    <= (w_diff_next == '0);
                        r_neg     <= w_diff_next[N-1];
                        r_ovf     <= (r_a[N-1] != r_b[N-1]) && (w_diff_next[N-1] != r_a[N-1]);
                        r_o_valid <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_k <= r_k + c_KW'(1);
                    end
                end
                S_DONE: begin
                    if (bus.o_ready) begin
                        r_o_valid <= 1'b0;
                        r_i_ready <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_o_valid <= 1'b0;
                    r_i_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.i_ready = r_i_ready;
    assign bus.o_valid = r_o_valid;
    assign bus.diff    = r_diff;
    assign bus.b_out   = r_b_out;
    assign bus.zero    = r_zero;
    assign bus.neg     = r_neg;
    assign bus.ovf     = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_sub32_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub32_seq
// Brief    : Directed bench for sub32_seq (W=8 and W=32) with a reference model.
// Revision : 1.0
// ============================================================================
module tb_sub32_seq;
    logic        clk;
    logic        rst;
    logic        iv[2];
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        bin_r;
    logic        ord;

    logic        ir[2];
    logic        ov[2];
    logic [31:0] dv[2];
    logic        bo[2];
    logic        zr[2];
    logic        ng[2];
    logic        of[2];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    sub32_seq_if #(.N(32)) bus8();
    sub32_seq_if #(.N(32)) bus32();

    sub32_seq #(.N(32), .W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));
    sub32_seq #(.N(32), .W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    assign bus8.i_valid  = iv[0];
    assign bus8.a        = a_r;
    assign bus8.b        = b_r;
    assign bus8.b_in     = bin_r;
    assign bus8.o_ready  = ord;
    assign bus32.i_valid = iv[1];
    assign bus32.a       = a_r;
    assign bus32.b       = b_r;
    assign bus32.b_in    = bin_r;
    assign bus32.o_ready = ord;

    assign ir[0] = bus8.i_ready;  assign ir[1] = bus32.i_ready;
    assign ov[0] = bus8.o_valid;  assign ov[1] = bus32.o_valid;
    assign dv[0] = bus8.diff;     assign dv[1] = bus32.diff;
    assign bo[0] = bus8.b_out;    assign bo[1] = bus32.b_out;
    assign zr[0] = bus8.zero;     assign zr[1] = bus32.zero;
    assign ng[0] = bus8.neg;      assign ng[1] = bus32.neg;
    assign of[0] = bus8.ovf;      assign of[1] = bus32.ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: transaction-level, latency given by chunk count.
    int          m_lat[2] = '{4, 1};
    bit          m_busy[2];
    bit          m_valid[2];
    int          m_cnt[2];
    logic [31:0] p_diff[2];
    logic [3:0]  p_flags[2];
    logic [31:0] m_diff[2];
    logic [3:0]  m_flags[2];   // {b_out, zero, neg, ovf}

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_busy[d] = 0; m_valid[d] = 0; m_cnt[d] = 0;
                m_diff[d] = '0; m_flags[d] = '0;
            end else if (!m_busy[d]) begin
                if (iv[d]) begin
                    logic [32:0] full;
                    full = {1'b0, a_r} - {1'b0, b_r} - {32'd0, bin_r};
                    p_diff[d]  = full[31:0];
                    p_flags[d] = {full[32], full[31:0] == 32'd0, full[31],
                                  (a_r[31] != b_r[31]) && (full[31] != a_r[31])};
                    m_busy[d] = 1; m_cnt[d] = 0;
                end
            end else if (!m_valid[d]) begin
                m_cnt[d]++;
                if (m_cnt[d] == m_lat[d]) begin
                    m_valid[d] = 1;
                    m_diff[d]  = p_diff[d];
                    m_flags[d] = p_flags[d];
                end
            end else if (ord) begin
                m_valid[d] = 0; m_busy[d] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("m%0d_i_ready", d), {31'd0, ir[d]}, {31'd0, !m_busy[d]});
                chk($sformatf("m%0d_o_valid", d), {31'd0, ov[d]}, {31'd0, m_valid[d]});
                if (!(m_busy[d] && !m_valid[d])) begin
                    chk($sformatf("m%0d_diff", d), dv[d], m_diff[d]);
                    chk($sformatf("m%0d_flags", d), {28'd0, bo[d], zr[d], ng[d], of[d]},
                        {28'd0, m_flags[d]});
                end
            end
        end
    end

    task automatic run_op(input int d, input logic [31:0] ia, input logic [31:0] ib,
                          input logic ibin, input logic hold,
                          input logic [31:0] ed, input logic [3:0] ef, input int elat);
        int lat;
        bit seen;
        lat = 0; seen = 0;
        @(negedge clk);
        a_r = ia; b_r = ib; bin_r = ibin; iv[d] = 1'b1; ord = !hold;
        @(negedge clk);
        iv[d] = 1'b0; a_r = ~ia; b_r = ia; bin_r = ~ibin;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (ov[d]) begin lat = i; seen = 1; break; end
        end
        chk($sformatf("d%0d_seen", d), {31'd0, seen}, 32'd1);
        chk($sformatf("d%0d_latency", d), lat, elat);
        chk($sformatf("d%0d_diff_lit", d), dv[d], ed);
        chk($sformatf("d%0d_flags_lit", d), {28'd0, bo[d], zr[d], ng[d], of[d]}, {28'd0, ef});
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                a_r = $urandom; b_r = $urandom; iv[d] = i[0];
                @(negedge clk);
                chk($sformatf("d%0d_bp_valid", d), {31'd0, ov[d]}, 32'd1);
                chk($sformatf("d%0d_bp_ready", d), {31'd0, ir[d]}, 32'd0);
                chk($sformatf("d%0d_bp_diff", d), dv[d], ed);
            end
            iv[d] = 1'b0;
            ord = 1'b1;
            @(negedge clk);
        end else begin
            @(negedge clk);
        end
        chk($sformatf("d%0d_ready_after", d), {31'd0, ir[d]}, 32'd1);
        chk($sformatf("d%0d_valid_after", d), {31'd0, ov[d]}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; iv[0] = 1'b1; iv[1] = 1'b1;
        a_r = 32'd9; b_r = 32'd4; bin_r = 1'b0; ord = 1'b0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        rst = 1'b0; iv[0] = 1'b0; iv[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_ready", d), {31'd0, ir[d]}, 32'd1);
            chk($sformatf("d%0d_rst_valid", d), {31'd0, ov[d]}, 32'd0);
            chk($sformatf("d%0d_rst_diff", d), dv[d], 32'd0);
            chk($sformatf("d%0d_rst_flags", d), {28'd0, bo[d], zr[d], ng[d], of[d]}, 32'd0);
        end

        // flags order: {b_out, zero, neg, ovf}
        run_op(0, 32'd5,         32'd3,         1'b0, 1'b0, 32'd2,         4'b0000, 4);
        run_op(0, 32'd0,         32'h1,         1'b0, 1'b0, 32'hFFFFFFFF,  4'b1010, 4);
        run_op(0, 32'd0,         32'd0,         1'b1, 1'b0, 32'hFFFFFFFF,  4'b1010, 4);
        run_op(0, 32'h00000100,  32'h00000001,  1'b0, 1'b0, 32'h000000FF,  4'b0000, 4);
        run_op(0, 32'hFFFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0, 32'd0,         4'b0100, 4);
        run_op(0, 32'h80000000,  32'h1,         1'b0, 1'b0, 32'h7FFFFFFF,  4'b0001, 4);
        run_op(0, 32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b0, 32'h80000000,  4'b1011, 4);
        run_op(0, 32'h12345678,  32'h01020304,  1'b0, 1'b1, 32'h11325374,  4'b0000, 4);
        run_op(1, 32'd5,         32'd3,         1'b0, 1'b0, 32'd2,         4'b0000, 1);
        run_op(1, 32'h00000100,  32'h00000001,  1'b0, 1'b0, 32'h000000FF,  4'b0000, 1);
        run_op(1, 32'h7FFFFFFF,  32'hFFFFFFFF,  1'b0, 1'b1, 32'h80000000,  4'b1011, 1);

        // Abort in the middle of RUN: the result must never appear.
        @(negedge clk);
        a_r = 32'd50; b_r = 32'd7; bin_r = 1'b0; iv[0] = 1'b1; ord = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_valid", {31'd0, ov[0]}, 32'd0);
            chk("abort_ready", {31'd0, ir[0]}, 32'd1);
        end
        chk("abort_diff_clear", dv[0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
